// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped programmable down-counter that sits behind the core's data
//   memory port. Address decode of the timer window happens upstream; this
//   block only sees the word offset. Supports one-shot and auto-reload
//   countdown and drives a level interrupt request back toward the core.
//
// Register map (word offset on addr):
//   0 CTRL   : [0]=EN, [2:1]=MODE (01 = auto-reload, else one-shot), [3]=IM
//   1 PRESET : reload value, read/write
//   2 COUNT  : current count, read-only
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk   in   system clock, rising-edge
//   rst   in   asynchronous active-low reset
//   addr  in   [1:0] word offset
//   we    in   write strobe
//   din   in   [WIDTH-1:0] write data
//   dout  out  [WIDTH-1:0] read data, combinational from addr and registers
//   irq   out  interrupt request = irq_flag & CTRL.IM
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int WIDTH     = 32,
    parameter int CTRL_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    localparam logic [1:0]       ADDR_CTRL   = 2'd0;
    localparam logic [1:0]       ADDR_PRESET = 2'd1;
    localparam logic [1:0]       ADDR_COUNT  = 2'd2;
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CTRL_BITS-1:0]   r_ctrl;
    logic [WIDTH-1:0]       r_preset;
    logic [WIDTH-1:0]       r_count;
    logic                   r_irq_flag;

    logic                   w_ctrl_wr;
    logic                   w_preset_wr;
    logic                   w_en;
    logic [1:0]             w_mode;
    logic                   w_im;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_expire;
    logic                   w_rearm;
    logic                   w_en_clr;

    assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
    assign w_preset_wr = we && (addr == ADDR_PRESET);
    assign w_en        = r_ctrl[0];
    assign w_mode      = r_ctrl[2:1];
    assign w_im        = r_ctrl[3];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control strobes. Decisions use the CTRL value
    // held before this edge, so a software write takes effect one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_expire    = 1'b0;
        w_rearm     = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > ONE) begin
                    w_dec = 1'b1;
                end else begin
                    // Covers COUNT of 1 and 0, so a zero PRESET still expires
                    // and the counter never wraps.
                    w_expire    = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_mode == 2'b01) begin
                    w_rearm     = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counter, flag and software-visible registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - ONE;
            end else if (w_expire) begin
                r_count <= '0;
            end

            // A software CTRL write clears the flag even on the expiry edge.
            if (w_ctrl_wr) begin
                r_irq_flag <= 1'b0;
            end else if (w_expire) begin
                r_irq_flag <= 1'b1;
            end else if (w_rearm) begin
                r_irq_flag <= 1'b0;
            end

            // Software value wins over the one-shot EN clear.
            if (w_ctrl_wr) begin
                r_ctrl <= din[CTRL_BITS-1:0];
            end else if (w_en_clr) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_preset_wr) begin
                r_preset <= din;
            end
        end
    end

    // Read mux
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = WIDTH'(r_ctrl);
            ADDR_PRESET: dout = r_preset;
            ADDR_COUNT:  dout = r_count;
            default:     dout = '0;
        endcase
    end

    assign irq = r_irq_flag & w_im;

endmodule

// File: tb/tb_timer_counter.sv
`timescale 1ns/1ps
module tb_timer_counter;

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t got;
    event smp_ev;

    timer_counter #(.WIDTH(32), .CTRL_BITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    always #10 clk = ~clk;

    // Monitor: pops the expected response whenever a read is presented.
    always begin
        @(smp_ev);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: read presented with no expectation queued");
        end else begin
            got = sb.pop_front();
            checks++;
            if (dout !== got.dout) begin
                failures++;
                $display("FAIL %s dout: got 0x%08h expected 0x%08h", got.name, dout, got.dout);
            end
            checks++;
            if (irq !== got.irq) begin
                failures++;
                $display("FAIL %s irq: got %b expected %b", got.name, irq, got.irq);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Write lands on the next rising edge; returns 2ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #2;
        we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] ed, input logic ei, input string nm);
        exp_t e;
        addr = a;
        #1;
        e.name = nm;
        e.dout = ed;
        e.irq  = ei;
        sb.push_back(e);
        ->smp_ev;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_cnt[8];
        int ar_irq[8];
        ar_cnt = '{2, 1, 0, 0, 2, 1, 0, 0};
        ar_irq = '{0, 0, 1, 0, 0, 0, 1, 0};

        rst  = 1'b0;
        we   = 1'b0;
        addr = 2'd0;
        din  = '0;
        #3;
        rd(2'd0, 32'h0, 1'b0, "init_ctrl");
        rd(2'd1, 32'h0, 1'b0, "init_preset");
        rd(2'd2, 32'h0, 1'b0, "init_count");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        // One-shot, PRESET=3, IM=1
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        cyc(2); rd(2'd2, 32'd3, 1'b0, "os_c3");
        cyc(1); rd(2'd2, 32'd2, 1'b0, "os_c2");
        cyc(1); rd(2'd2, 32'd1, 1'b0, "os_c1");
        cyc(1); rd(2'd2, 32'd0, 1'b1, "os_c0_irq");
        cyc(1); rd(2'd0, 32'h8, 1'b1, "os_ctrl8");
        cyc(2); rd(2'd2, 32'd0, 1'b1, "os_irq_hold");
        wr(2'd0, 32'h8);
        rd(2'd0, 32'h8, 1'b0, "os_irq_clr");

        // Auto-reload, PRESET=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            rd(2'd2, 32'(ar_cnt[i]), ar_irq[i][0], $sformatf("ar_%0d", i));
            if (i < 7) cyc(1);
        end
        // EN cleared while the FSM is in LOAD: LOAD finishes, then idles.
        wr(2'd0, 32'h0);
        rd(2'd2, 32'd2, 1'b0, "ar_load_done");
        cyc(1); rd(2'd2, 32'd2, 1'b0, "ar_stop_hold");

        // Masked early expiry, PRESET=0, IM=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        cyc(2); rd(2'd2, 32'd0, 1'b0, "mk_load0");
        cyc(1); rd(2'd0, 32'h1, 1'b0, "mk_int_entry");
        cyc(1); rd(2'd0, 32'h0, 1'b0, "mk_en_cleared");
        wr(2'd0, 32'h8);
        rd(2'd0, 32'h8, 1'b0, "mk_im_no_irq");

        // Pause and PRESET isolation, PRESET=10
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        cyc(5); rd(2'd2, 32'd7, 1'b0, "pa_c7");
        wr(2'd0, 32'h0);
        rd(2'd2, 32'd6, 1'b0, "pa_c6");
        cyc(2); rd(2'd2, 32'd6, 1'b0, "pa_hold");
        wr(2'd1, 32'd20);
        rd(2'd2, 32'd6, 1'b0, "pa_preset_iso");
        rd(2'd1, 32'd20, 1'b0, "pa_preset_rd");
        wr(2'd0, 32'h1);
        rd(2'd2, 32'd6, 1'b0, "pa_reen0");
        cyc(1); rd(2'd2, 32'd6, 1'b0, "pa_reen1");
        cyc(1); rd(2'd2, 32'd20, 1'b0, "pa_reload20");
        wr(2'd0, 32'h0);
        cyc(1); rd(2'd2, 32'd19, 1'b0, "pa_c19");

        // Register map
        rd(2'd3, 32'h0, 1'b0, "rm_addr3");
        wr(2'd3, 32'hDEADBEEF);
        rd(2'd3, 32'h0, 1'b0, "rm_addr3_wr");
        wr(2'd2, 32'h55);
        rd(2'd2, 32'd19, 1'b0, "rm_count_ro");
        wr(2'd0, 32'hFFFFFFFF);
        rd(2'd0, 32'hF, 1'b0, "rm_ctrl_mask");
        wr(2'd0, 32'h0);
        cyc(3);

        // Asynchronous reset mid-count at COUNT=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        cyc(2); rd(2'd2, 32'd5, 1'b0, "rs_c5");
        rst = 1'b0;
        #1;
        rd(2'd2, 32'h0, 1'b0, "rs_count");
        rd(2'd0, 32'h0, 1'b0, "rs_ctrl");
        rd(2'd1, 32'h0, 1'b0, "rs_preset");
        cyc(1); rd(2'd2, 32'h0, 1'b0, "rs_held");
        rst = 1'b1;
        cyc(3); rd(2'd2, 32'h0, 1'b0, "rs_idle");
        rd(2'd0, 32'h0, 1'b0, "rs_idle_ctrl");

        #5;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
